// File: rtl/shifter_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shifter_stage_pkg
// Brief    : Shift codes, widths, buffer states and amount-mode helper.
// Revision : 1.0
// ============================================================================
package shifter_stage_pkg;

  localparam int FULLW      = 32;
  localparam int WIDTH      = 8;
  localparam int REGAW      = 4;
  localparam int SHIFTCODEW = 2;

  localparam logic [SHIFTCODEW-1:0] LSL = 2'd0;
  localparam logic [SHIFTCODEW-1:0] LSR = 2'd1;
  localparam logic [SHIFTCODEW-1:0] ASR = 2'd2;
  localparam logic [SHIFTCODEW-1:0] ROR = 2'd3;

  localparam logic [1:0] SHSTATE_EMPTY = 2'd0;
  localparam logic [1:0] SHSTATE_ONE   = 2'd1;
  localparam logic [1:0] SHSTATE_TWO   = 2'd2;

  typedef enum logic [1:0] {
    AMT_IMM = 2'd0,
    AMT_ROT = 2'd1,
    AMT_REG = 2'd2
  } amt_mode_e;

  // Register-specified amounts take precedence over the rotate-immediate form.
  function automatic amt_mode_e sel_mode(input logic reg_shift, input logic rot_imm);
    if (reg_shift) return AMT_REG;
    if (rot_imm)   return AMT_ROT;
    return AMT_IMM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_stage_barrel_core.sv
`default_nettype none
// ============================================================================
// Module   : barrel_core
// Brief    : Combinational ARM operand-2 shifter producing result and carry.
// Revision : 1.0
// ============================================================================
module barrel_core
  import shifter_stage_pkg::*;
#(
  parameter int W = shifter_stage_pkg::FULLW
) (
  input  logic [W-1:0]          src,
  input  logic [SHIFTCODEW-1:0] code,
  input  amt_mode_e             mode,
  input  logic [4:0]            imm_amt,
  input  logic [7:0]            reg_amt,
  input  logic                  c_in,
  output logic [W-1:0]          op2,
  output logic                  c_out
);

  localparam int            AW       = $clog2(W) + 1;
  localparam logic [AW-1:0] AMT_FULL = AW'(W);
  localparam logic [7:0]    REG_FULL = 8'(W);

  logic [AW-1:0] sh_amt;
  logic [AW-1:0] rot_amt;
  logic [W:0]    lsl_ext;
  logic [W:0]    lsr_ext;
  logic [W:0]    asr_ext;
  logic [W-1:0]  sh_op2;
  logic          sh_c;
  logic [2*W-1:0] rot_dbl;
  logic [W-1:0]  ror_res;

  // Immediate LSR/ASR #0 encode #32; register amounts saturate at W.
  always_comb begin
    sh_amt  = AMT_FULL;
    rot_amt = '0;
    case (mode)
      AMT_ROT: rot_amt = AW'({imm_amt[3:0], 1'b0});
      AMT_REG: begin
        sh_amt  = (reg_amt >= REG_FULL) ? AMT_FULL : reg_amt[AW-1:0];
        rot_amt = AW'(reg_amt[4:0]);
      end
      default: begin
        sh_amt  = (imm_amt == 5'd0) ? AMT_FULL : AW'(imm_amt);
        rot_amt = AW'(imm_amt);
      end
    endcase
  end

  // One extra bit carries the last bit shifted out.
  always_comb begin
    lsl_ext = {1'b0, src} << sh_amt;
    lsr_ext = {src, 1'b0} >> sh_amt;
    asr_ext = $signed({src, 1'b0}) >>> sh_amt;
    rot_dbl = {src, src} >> rot_amt;
    ror_res = rot_dbl[W-1:0];
    case (code)
      LSL:     {sh_c, sh_op2} = lsl_ext;
      LSR:     {sh_op2, sh_c} = lsr_ext;
      default: {sh_op2, sh_c} = asr_ext;
    endcase
  end

  always_comb begin
    op2   = src;
    c_out = c_in;
    case (mode)
      AMT_ROT: begin
        if (rot_amt != '0) begin
          op2   = ror_res;
          c_out = ror_res[W-1];
        end
      end
      AMT_REG: begin
        if (reg_amt != 8'd0) begin
          if (code == ROR) begin
            if (rot_amt == '0) begin
              c_out = src[W-1];
            end else begin
              op2   = ror_res;
              c_out = ror_res[W-1];
            end
          end else if ((code != ASR) && (reg_amt > REG_FULL)) begin
            op2   = '0;
            c_out = 1'b0;
          end else begin
            op2   = sh_op2;
            c_out = sh_c;
          end
        end
      end
      default: begin
        if (code == ROR) begin
          if (imm_amt == 5'd0) begin
            {op2, c_out} = {c_in, src};
          end else begin
            op2   = ror_res;
            c_out = ror_res[W-1];
          end
        end else if (!((code == LSL) && (imm_amt == 5'd0))) begin
          op2   = sh_op2;
          c_out = sh_c;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shifter_stage.sv
`default_nettype none
// ============================================================================
// Module   : shifter_stage
// Brief    : Registered operand-2 shifter stage with a two-entry skid buffer.
//            Define SHIFTER_REG_SHIFT_EN to enable register-specified shifts.
// Revision : 1.0
// ============================================================================
module shifter_stage
  import shifter_stage_pkg::*;
#(
  parameter int FULLW = shifter_stage_pkg::FULLW,
  parameter int SHW   = shifter_stage_pkg::WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FULLW-1:0]      rm_val,
  input  logic [FULLW-1:0]      bypass_rm,
  input  logic                  should_bypass_rm,
  input  logic [SHIFTCODEW-1:0] shiftcode,
  input  logic [SHW-1:0]        shiftby,
  input  logic                  rot_imm,
  input  logic                  rs_shift,
  input  logic [FULLW-1:0]      rs_val,
  input  logic                  c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULLW-1:0]      op2,
  output logic                  shc_out
);

  logic [FULLW-1:0] src;
  amt_mode_e        mode;
  logic [7:0]       reg_amt;
  logic [FULLW-1:0] res_op2;
  logic             res_c;

  assign src = should_bypass_rm ? bypass_rm : rm_val;

`ifdef SHIFTER_REG_SHIFT_EN
  logic unused_bits;
  assign mode        = sel_mode(rs_shift, rot_imm);
  assign reg_amt     = rs_val[7:0];
  assign unused_bits = ^{shiftby[SHW-1:5], rs_val[FULLW-1:8]};
`else
  logic unused_bits;
  assign mode        = sel_mode(1'b0, rot_imm);
  assign reg_amt     = 8'd0;
  assign unused_bits = ^{shiftby[SHW-1:5], rs_shift, rs_val};
`endif

  barrel_core #(
    .W (FULLW)
  ) u_barrel_core (
    .src     (src),
    .code    (shiftcode),
    .mode    (mode),
    .imm_amt (shiftby[4:0]),
    .reg_amt (reg_amt),
    .c_in    (c_in),
    .op2     (res_op2),
    .c_out   (res_c)
  );

  logic [1:0]       state_q, state_d;
  logic [FULLW-1:0] m_op2_q, m_op2_d;
  logic [FULLW-1:0] s_op2_q, s_op2_d;
  logic             m_c_q, m_c_d;
  logic             s_c_q, s_c_d;
  logic             xfer_in;
  logic             xfer_out;

  // Both handshake outputs decode the state flop only, never out_ready.
  assign in_ready  = (state_q != SHSTATE_TWO);
  assign out_valid = (state_q != SHSTATE_EMPTY);
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;
  assign op2       = m_op2_q;
  assign shc_out   = m_c_q;

  always_comb begin
    state_d = state_q;
    m_op2_d = m_op2_q;
    m_c_d   = m_c_q;
    s_op2_d = s_op2_q;
    s_c_d   = s_c_q;
    case (state_q)
      SHSTATE_EMPTY: begin
        if (xfer_in) begin
          state_d = SHSTATE_ONE;
          m_op2_d = res_op2;
          m_c_d   = res_c;
        end
      end
      SHSTATE_ONE: begin
        if (xfer_in && xfer_out) begin
          m_op2_d = res_op2;
          m_c_d   = res_c;
        end else if (xfer_in) begin
          state_d = SHSTATE_TWO;
          s_op2_d = res_op2;
          s_c_d   = res_c;
        end else if (xfer_out) begin
          state_d = SHSTATE_EMPTY;
        end
      end
      SHSTATE_TWO: begin
        if (xfer_out) begin
          state_d = SHSTATE_ONE;
          m_op2_d = s_op2_q;
          m_c_d   = s_c_q;
        end
      end
      default: state_d = SHSTATE_EMPTY;
    endcase
    if (flush) state_d = SHSTATE_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHSTATE_EMPTY;
      m_op2_q <= '0;
      m_c_q   <= 1'b0;
      s_op2_q <= '0;
      s_c_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_op2_q <= m_op2_d;
      m_c_q   <= m_c_d;
      s_op2_q <= s_op2_d;
      s_c_q   <= s_c_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shifter_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_stage
// Brief    : Directed self-checking bench for shifter_stage.
// Revision : 1.0
// ============================================================================
module tb_shifter_stage;
  import shifter_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] rm_val, bypass_rm, rs_val, op2;
  logic        should_bypass_rm, rot_imm, rs_shift, c_in;
  logic [1:0]  shiftcode;
  logic [7:0]  shiftby;
  logic        out_valid, out_ready, shc_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shifter_stage #(
    .FULLW (32),
    .SHW   (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .rm_val           (rm_val),
    .bypass_rm        (bypass_rm),
    .should_bypass_rm (should_bypass_rm),
    .shiftcode        (shiftcode),
    .shiftby          (shiftby),
    .rot_imm          (rot_imm),
    .rs_shift         (rs_shift),
    .rs_val           (rs_val),
    .c_in             (c_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .op2              (op2),
    .shc_out          (shc_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [31:0] rm, input logic [31:0] byp, input logic sel,
                        input logic [1:0] code, input logic [7:0] sb, input logic rot,
                        input logic rs, input logic [31:0] rsv, input logic cin);
    rm_val           = rm;
    bypass_rm        = byp;
    should_bypass_rm = sel;
    shiftcode        = code;
    shiftby          = sb;
    rot_imm          = rot;
    rs_shift         = rs;
    rs_val           = rsv;
    c_in             = cin;
  endtask

  // One op through an idle stage with the ALU ready: result after one edge, gone after the next.
  task automatic run_op(input string tag, input logic [31:0] rm, input logic [31:0] byp,
                        input logic sel, input logic [1:0] code, input logic [7:0] sb,
                        input logic rot, input logic rs, input logic [31:0] rsv,
                        input logic cin, input logic [31:0] exp_op2, input logic exp_c);
    set_op(rm, byp, sel, code, sb, rot, rs, rsv, cin);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, ".vld"}, 64'(out_valid), 64'd1);
    check_eq({tag, ".op2"}, 64'(op2), 64'(exp_op2));
    check_eq({tag, ".c"}, 64'(shc_out), 64'(exp_c));
    @(posedge clk); #1;
    check_eq({tag, ".drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(32'd0, 32'd0, 1'b0, LSL, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.vld", 64'(out_valid), 64'd0);
    check_eq("rst.rdy", 64'(in_ready), 64'd1);
    check_eq("rst.op2", 64'(op2), 64'd0);
    check_eq("rst.c", 64'(shc_out), 64'd0);
    reset = 1'b0;

    run_op("lsr0",   32'h80000001, 32'h0, 1'b0, LSR, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000000, 1'b1);
    run_op("rrx",    32'h00000003, 32'h0, 1'b0, ROR, 8'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80000001, 1'b1);
    run_op("rot8",   32'h12345678, 32'hFF, 1'b1, LSL, 8'd4, 1'b1, 1'b0, 32'd0, 1'b0, 32'hFF000000, 1'b1);
    run_op("rot0",   32'h12345678, 32'hFF, 1'b1, LSR, 8'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h000000FF, 1'b0);
    run_op("rot30",  32'h00000001, 32'h0, 1'b0, ASR, 8'h1F, 1'b1, 1'b0, 32'd0, 1'b1, 32'h00000004, 1'b0);
    run_op("lsl4",   32'hF0000001, 32'h0, 1'b0, LSL, 8'd4, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000010, 1'b1);
    run_op("lsl0",   32'h00001234, 32'h0, 1'b0, LSL, 8'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h00001234, 1'b1);
    run_op("asr0",   32'h80000000, 32'h0, 1'b0, ASR, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1);
    run_op("asr4",   32'h80000010, 32'h0, 1'b0, ASR, 8'd4, 1'b0, 1'b0, 32'd0, 1'b1, 32'hF8000001, 1'b0);
    run_op("lsr1",   32'h00000003, 32'h0, 1'b0, LSR, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000001, 1'b1);
    run_op("ror8",   32'h000000AB, 32'h0, 1'b0, ROR, 8'd8, 1'b0, 1'b0, 32'd0, 1'b0, 32'hAB000000, 1'b1);
`ifdef SHIFTER_REG_SHIFT_EN
    run_op("rs_lsl33", 32'hFFFFFFFF, 32'h0, 1'b0, LSL, 8'd3, 1'b0, 1'b1, 32'd33, 1'b1, 32'h0, 1'b0);
    run_op("rs_lsl32", 32'hFFFFFFFF, 32'h0, 1'b0, LSL, 8'd3, 1'b0, 1'b1, 32'd32, 1'b0, 32'h0, 1'b1);
    run_op("rs_lsr32", 32'h80000000, 32'h0, 1'b0, LSR, 8'd3, 1'b0, 1'b1, 32'd32, 1'b0, 32'h0, 1'b1);
    run_op("rs_asr40", 32'h80000000, 32'h0, 1'b0, ASR, 8'd3, 1'b0, 1'b1, 32'd40, 1'b0, 32'hFFFFFFFF, 1'b1);
    run_op("rs_zero",  32'h0000ABCD, 32'h0, 1'b0, LSR, 8'd3, 1'b0, 1'b1, 32'h00000100, 1'b1, 32'h0000ABCD, 1'b1);
    run_op("rs_ror32", 32'h80000001, 32'h0, 1'b0, ROR, 8'd3, 1'b0, 1'b1, 32'd32, 1'b0, 32'h80000001, 1'b1);
    run_op("rs_lsl4",  32'h00000001, 32'h0, 1'b0, LSL, 8'd3, 1'b0, 1'b1, 32'h00000F04, 1'b1, 32'h00000010, 1'b0);
`else
    run_op("rs_ign",   32'h00000001, 32'h0, 1'b0, LSL, 8'd2, 1'b0, 1'b1, 32'd33, 1'b1, 32'h00000004, 1'b0);
`endif

    // Backpressure: A and B fill M and S, C stalls until the ALU drains.
    out_ready = 1'b0;
    set_op(32'd1, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("bp.a_vld", 64'(out_valid), 64'd1);
    check_eq("bp.rdy1", 64'(in_ready), 64'd1);
    set_op(32'd2, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("bp.rdy2", 64'(in_ready), 64'd0);
    check_eq("bp.hold1", 64'(op2), 64'd2);
    set_op(32'd3, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("bp.rdy3", 64'(in_ready), 64'd0);
    check_eq("bp.hold2", 64'(op2), 64'd2);
    check_eq("bp.vld", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp.b", 64'(op2), 64'd4);
    check_eq("bp.rdy4", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp.c", 64'(op2), 64'd6);
    check_eq("bp.c_vld", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check_eq("bp.empty", 64'(out_valid), 64'd0);

    // Flush while full, with a new op offered the same cycle.
    out_ready = 1'b0;
    set_op(32'd5, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_op(32'd6, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("fl.two", 64'(in_ready), 64'd0);
    set_op(32'd9, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl.vld", 64'(out_valid), 64'd0);
    check_eq("fl.rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("fl.quiet", 64'(out_valid), 64'd0);
    end

    // Reset with flush mid-operation, then first post-reset op is accepted.
    out_ready = 1'b0;
    set_op(32'd7, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    check_eq("mr.vld", 64'(out_valid), 64'd0);
    check_eq("mr.op2", 64'(op2), 64'd0);
    check_eq("mr.rdy", 64'(in_ready), 64'd1);
    reset = 1'b0;
    flush = 1'b0;
    set_op(32'd8, 32'd0, 1'b0, LSL, 8'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("mr.acc", 64'(out_valid), 64'd1);
    check_eq("mr.res", 64'(op2), 64'h10);
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
